// File: rtl/demux_pkg.sv
// Shared types and helpers for the 1-to-8 demux controller and datapath.
// Latency: n/a (types and a combinational decode function only).
// Backpressure: n/a.
package demux_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic MODE_ADDR = 1'b0;
    localparam logic MODE_RR   = 1'b1;

    // Callers size the result down to their own sink count.
    function automatic logic [31:0] onehot(input logic [4:0] idx);
        return 32'd1 << idx;
    endfunction

endpackage

// File: rtl/demux_stall_timer.sv
// Counts stalled HOLD cycles and flags the cycle on which the held word expires.
// Latency: fire is combinational from the count and en; the count updates on the next edge.
// Backpressure: en is low on a delivering cycle, so a delivery always beats expiry.
module demux_stall_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic fire
);

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [TW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + TW'(1);
        end
    end

    // TIMEOUT of zero disables expiry; the counter just free-runs harmlessly.
    assign fire = (TIMEOUT != 0) && en && (cnt == LAST);

endmodule

// File: rtl/demux_dispatch_ctrl.sv
// Steers each accepted word to one of N_OUT sinks, addressed or round-robin.
// Latency: 1 cycle from capture to out_valid; sustains 1 word/cycle when the sink is ready.
// Backpressure: in_ready follows the addressed sink's ready; stalled words drop after TIMEOUT.
module demux_dispatch_ctrl
    import demux_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int N_OUT   = 8,
    parameter int SEL_W   = 3,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mode,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic [SEL_W-1:0]  in_dest,
    output logic              in_ready,
    input  logic [N_OUT-1:0]  out_ready,
    output logic [SEL_W-1:0]  sel,
    output logic [N_OUT-1:0]  out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic [CNT_W-1:0]  drop_cnt,
    output logic [SEL_W-1:0]  rr_ptr
);

    state_t            state;
    state_t            state_nxt;
    logic              deliver;
    logic              fire;
    logic              done;
    logic              capture;
    logic              word_rr;
    logic [SEL_W-1:0]  rr_eff;

    assign deliver  = (state == HOLD) && out_ready[sel];
    assign done     = deliver || fire;
    assign in_ready = (state == IDLE) || done;
    assign capture  = in_valid && in_ready;

    // A word captured on the same edge that retires an RR word must see the advanced pointer.
    assign rr_eff = (done && word_rr) ? rr_ptr + SEL_W'(1) : rr_ptr;

    demux_stall_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (capture || done),
        .en    ((state == HOLD) && !deliver),
        .fire  (fire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (capture) state_nxt = HOLD;
            HOLD: if (done && !capture) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state == HOLD);
        out_valid = '0;
        if (state == HOLD) begin
            out_valid = N_OUT'(onehot(5'(sel)));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data <= '0;
            sel      <= '0;
            word_rr  <= MODE_ADDR;
            rr_ptr   <= '0;
            drop_cnt <= '0;
        end else begin
            rr_ptr <= rr_eff;
            if (capture) begin
                out_data <= in_data;
                sel      <= (mode == MODE_RR) ? rr_eff : in_dest;
                word_rr  <= mode;
            end
            if (fire && (drop_cnt != {CNT_W{1'b1}})) begin
                drop_cnt <= drop_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_demux_dispatch_ctrl.sv
// Randomised and directed bench for demux_dispatch_ctrl against a word-level reference model.
module tb_demux_dispatch_ctrl;

    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       mode = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic [2:0] in_dest = '0;
    logic       in_ready;
    logic [7:0] out_ready = '0;
    logic [2:0] sel;
    logic [7:0] out_valid;
    logic [7:0] out_data;
    logic       busy;
    logic [7:0] drop_cnt;
    logic [2:0] rr_ptr;

    int checks = 0;
    int failures = 0;

    // Reference model: the one held word plus the controller's bookkeeping.
    bit       m_hold;
    bit [7:0] m_data;
    int       m_sel;
    bit       m_rr;
    int       m_age;
    int       m_rrp;
    int       m_drop;

    always #5 clk = ~clk;

    demux_dispatch_ctrl #(
        .DATA_W (8), .N_OUT (8), .SEL_W (3), .TIMEOUT (TO), .CNT_W (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_dest   (in_dest),
        .in_ready  (in_ready),
        .out_ready (out_ready),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .busy      (busy),
        .drop_cnt  (drop_cnt),
        .rr_ptr    (rr_ptr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_hold = 0; m_data = '0; m_sel = 0; m_rr = 0;
        m_age = 0; m_rrp = 0; m_drop = 0;
    endfunction

    // The held word expires on its TO-th consecutive cycle without acceptance.
    function automatic bit m_expires(input logic [7:0] ordy);
        return m_hold && !ordy[m_sel] && (TO != 0) && (m_age + 1 == TO);
    endfunction

    function automatic bit m_ready(input logic [7:0] ordy);
        return !m_hold || ordy[m_sel] || m_expires(ordy);
    endfunction

    task automatic check_outputs();
        chk("in_ready", 32'(in_ready), 32'(m_ready(out_ready)));
        chk("busy", 32'(busy), 32'(m_hold));
        chk("out_valid", 32'(out_valid), m_hold ? (32'd1 << m_sel) : 32'd0);
        chk("sel", 32'(sel), 32'(m_sel));
        chk("out_data", 32'(out_data), 32'(m_data));
        chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
        chk("rr_ptr", 32'(rr_ptr), 32'(m_rrp));
    endtask

    function automatic void model_edge(input bit v, input bit [7:0] d, input int dst,
                                       input bit md, input logic [7:0] ordy);
        bit dlv, exp, rdy, fin;
        dlv = m_hold && ordy[m_sel];
        exp = m_expires(ordy);
        rdy = m_ready(ordy);
        fin = dlv || exp;
        if (exp && m_drop < 255) m_drop++;
        if (fin && m_rr) m_rrp = (m_rrp + 1) % 8;
        if (v && rdy) begin
            m_hold = 1; m_data = d; m_rr = md; m_age = 0;
            m_sel  = md ? m_rrp : dst;
        end else if (fin) begin
            m_hold = 0;
        end else if (m_hold) begin
            m_age++;
        end
    endfunction

    task automatic step(input bit v, input bit [7:0] d, input int dst,
                        input bit md, input logic [7:0] ordy);
        @(negedge clk);
        in_valid = v; in_data = d; in_dest = 3'(dst); mode = md; out_ready = ordy;
        #1;
        check_outputs();
        @(posedge clk);
        model_edge(v, d, dst, md, ordy);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = '0;
        model_reset();
        #1;
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        #1;
        check_outputs();
        do_reset();

        step(0, 8'h00, 0, 0, 8'hFF);
        step(0, 8'h00, 0, 0, 8'h00);

        for (int i = 0; i < 8; i++) step(1, 8'(8'hA0 + i), i, 0, 8'hFF);
        step(0, 8'h00, 0, 0, 8'hFF);

        for (int i = 0; i < 10; i++) step(1, 8'($urandom), 5, 1, 8'hFF);
        step(0, 8'h00, 5, 1, 8'hFF);
        #1 chk("rr_after_10", 32'(rr_ptr), 32'd2);

        step(1, 8'h5C, 3, 0, 8'h00);
        for (int i = 0; i < 5; i++) step(0, 8'h00, 0, 0, 8'hF7);
        step(0, 8'h00, 0, 0, 8'h08);
        step(0, 8'h00, 0, 0, 8'h00);
        #1 chk("bp_no_drop", 32'(drop_cnt), 32'd0);

        do_reset();
        step(1, 8'h33, 7, 1, 8'h00);
        for (int i = 0; i < TO; i++) step(0, 8'h00, 0, 0, 8'h00);
        #1 chk("to_drop", 32'(drop_cnt), 32'd1);
        chk("to_rr", 32'(rr_ptr), 32'd1);
        chk("to_idle", 32'(busy), 32'd0);
        step(1, 8'h44, 6, 1, 8'h00);
        #1 chk("to_next_sel", 32'(sel), 32'd1);

        do_reset();
        step(1, 8'h55, 2, 1, 8'h00);
        for (int i = 0; i < TO - 1; i++) step(0, 8'h00, 0, 0, 8'h00);
        step(0, 8'h00, 0, 0, 8'h01);
        #1 chk("tie_no_drop", 32'(drop_cnt), 32'd0);
        chk("tie_rr", 32'(rr_ptr), 32'd1);

        step(1, 8'h66, 4, 0, 8'h00);
        step(0, 8'h00, 0, 0, 8'h00);
        #1 chk("pre_rst_valid", 32'(out_valid), 32'h10);
        #1 rst_n = 1'b0;
        #1 chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);
        chk("rst_rr", 32'(rr_ptr), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        model_reset();
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;

        for (int i = 0; i < 1500; i++) begin
            logic [7:0] r;
            case ($urandom_range(0, 3))
                0: r = 8'h00;
                1: r = 8'hFF;
                default: r = 8'($urandom);
            endcase
            step($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 7),
                 1'($urandom), r);
        end

        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 1), 8'($urandom), $urandom_range(0, 7), 1'($urandom),
                 ($urandom_range(0, 19) == 0) ? 8'($urandom) : 8'h00);
        end

        // Long total stall drives the drop counter into saturation.
        for (int i = 0; i < 4500; i++) begin
            step(1, 8'($urandom), $urandom_range(0, 7), 1'($urandom), 8'h00);
        end
        #1 chk("drop_sat", 32'(drop_cnt), 32'd255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/demux_dispatch_ctrl.md
Name: demux_dispatch_ctrl

Overview:
- Sequencing controller for the 1-to-8 demux datapath.
- Accepts a valid/ready input stream and registers each word into a one-entry holding stage.
- Drives demux select plus a one-hot valid to the addressed sink, in either addressed mode or round-robin scan mode.
- Provides per-sink backpressure, an optional stall timeout with drop, and status counters; sits between a single producer and eight consumers.

Parameters:
- DATA_W, 8, width of data word steered to sinks
- N_OUT, 8, number of sinks; must equal 2**SEL_W
- SEL_W, 3, select width
- TIMEOUT, 16, stall cycles before a held word is dropped; 0 disables timeout
- CNT_W, 8, width of drop counter (saturating)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- mode  in  1  0 = addressed (use in_dest), 1 = round-robin scan; sampled at capture only
- in_valid  in  1  producer word valid
- in_data  in  DATA_W  producer word
- in_dest  in  SEL_W  destination index (addressed mode only)
- in_ready  out  1  controller can accept this cycle
- out_ready  in  N_OUT  per-sink ready
- sel  out  SEL_W  registered demux select of held word
- out_valid  out  N_OUT  one-hot valid, bit sel set while HOLD
- out_data  out  DATA_W  registered held word
- busy  out  1  high in HOLD
- drop_cnt  out  CNT_W  count of timed-out words, saturates at all-ones
- rr_ptr  out  SEL_W  next round-robin destination

Behaviour:
- Reset, async on rst_n low:
  - State IDLE; sel=0, out_valid=0, out_data=0, busy=0, drop_cnt=0, rr_ptr=0, stall counter=0.
  - in_ready=1 (combinational from IDLE).
- States: IDLE, HOLD.
- Sink acceptance: deliver = HOLD && out_ready[sel].
- in_ready = IDLE || deliver || timeout_fire. Combinational; depends on out_ready.
- Capture: in_valid && in_ready at rising edge.
  - Load out_data=in_data.
  - Load sel = mode ? rr_ptr : in_dest.
  - Clear stall counter; go to or stay in HOLD.
  - out_valid = one-hot(sel) from the next cycle. Latency from capture to sink visibility is 1 cycle.
- HOLD, deliver:
  - Word is consumed that edge.
  - If the word was captured in RR mode, rr_ptr increments, wrapping N_OUT-1 -> 0.
  - If a capture happens the same edge, stay in HOLD with the new word (throughput 1 word/cycle). Otherwise go to IDLE, out_valid=0.
- HOLD, no deliver:
  - Stall counter increments.
  - timeout_fire when TIMEOUT != 0 and the counter reaches TIMEOUT-1 with no deliver. The word is dropped: drop_cnt +1 (saturating), rr_ptr advances if the word was RR. Then a same-cycle capture or IDLE, exactly as for deliver.
- deliver and timeout_fire in the same cycle: deliver wins; no drop.
- Registered word-mode flag remembers RR vs addressed per held word; mode changes while in HOLD do not affect the held word.
- out_data and sel hold their last values in IDLE; only out_valid deasserts.
- Sink ready on bits other than sel is ignored.
- Reset mid-HOLD: word discarded, no drop counted, all outputs return to reset values immediately.
- TIMEOUT=0: HOLD waits indefinitely; drop_cnt stays 0.

Decomposition:
- Shared package demux_pkg holds:
  - state enum (IDLE, HOLD)
  - mode constants MODE_ADDR=0, MODE_RR=1
  - a one-hot decode function, also usable by the demux datapath
- One natural sub-module: demux_stall_timer (stall counter, TIMEOUT compare, timeout_fire output, clear/enable inputs).
- The rest stays flat.

Test Plan:
- Reset: hold rst_n=0 -> out_valid=0, sel=0, drop_cnt=0, in_ready=1, busy=0; release, no spurious valid.
- Addressed mode, out_ready=8'hFF, in_valid held with in_dest cycling 0..7 and data 8'hA0..8'hA7 -> one word per cycle; out_valid = 8'h01, 8'h02, …, 8'h80, each 1 cycle after capture with matching out_data.
- RR mode, 10 words, out_ready=8'hFF -> sel = 0..7, 0, 1; rr_ptr=2 at end; in_dest ignored (drive 3'd5 constantly).
- Backpressure: addressed dest 3 data 8'h5C, out_ready[3]=0 for 5 cycles, then 1 -> out_valid=8'h08 steady 6 cycles, in_ready=0 during stall, high on delivery cycle, drop_cnt unchanged.
- Timeout: TIMEOUT=16, RR word to sink 0 with out_ready=0 -> drop at 16th stall cycle, drop_cnt=1, rr_ptr=1, next word goes to sink 1; out_ready[0] rising on the same cycle as the timeout -> delivered, drop_cnt stays 0.
- Reset mid-HOLD: assert rst_n=0 while out_valid=8'h10 -> out_valid=0 asynchronously, busy=0, drop_cnt=0, rr_ptr=0.
